spi_secondary: RTL and testbench
================================

# spi_secondary

Parametrised SPI secondary (peripheral) endpoint that replaces the bit-level behavioural shift register used in SPI benches with a synthesizable, system-clocked block. It oversamples `sclk`, `cs_n` and `mosi` in the `clk` domain, supports all four CPOL/CPHA modes and any word width, and exchanges whole words with local logic through valid/ready handshakes. It sits opposite `spi_core` in loopback benches and inside designs acting as an SPI target.

## Interface
- `DWIDTH`, 8: word width in bits, ≥ 2; MSB first.
- `CPOL`, 0: idle level of `sclk`.
- `CPHA`, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `clk`  in  1  system clock; one clock; all state is in this domain.
- `rst`  in  1  reset; reset is asynchronous and active-low.
- `sclk`  in  1  SPI clock from the primary, asynchronous to `clk`.
- `cs_n`  in  1  chip select, active-low, asynchronous.
- `mosi`  in  1  serial data in, asynchronous.
- `miso`  out  1  serial data out.
- `miso_oe`  out  1  high while the synchronized `cs_n` is low.
- `tx_data`  in  DWIDTH  next word to transmit.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  transmit holding buffer empty.
- `rx_data`  out  DWIDTH  last received word.
- `rx_valid`  out  1  `rx_data` holds an unread word.
- `rx_ready`  in  1  local logic consumes `rx_data`.
- `overrun`  out  1  sticky overrun flag.
- `overrun_clr`  in  1  clears `overrun`.

## Operation
- Inputs pass through 2-flop synchronizers, then an edge-detect register; sample edge = leading edge (rising if CPOL=0, falling if CPOL=1) when CPHA=0, else the trailing edge; shift edge is the other edge.
- Transmit holding buffer: loaded when `tx_valid && tx_ready`; `tx_ready` drops the next cycle and rises when the buffer is moved to the shift register.
- States: IDLE (`cs_n` high), ACTIVE.
- IDLE -> ACTIVE on synchronized `cs_n` fall: `bit_cnt`=0; shift register loaded from holding buffer if full, else all zeros. CPHA=0: MSB driven on `miso` immediately. CPHA=1: MSB driven on the first shift edge.
- ACTIVE, sample edge: shift in `mosi`, `bit_cnt`++. On the DWIDTH-th sample: word captured to `rx_data`, `rx_valid` set, `bit_cnt`=0, shift register reloaded (holding buffer or zeros) for back-to-back frames.
- ACTIVE, shift edge: next bit onto `miso`; CPHA=0 trailing edge after the last sample presents the next word's MSB.
- ACTIVE -> IDLE on synchronized `cs_n` rise, any `bit_cnt`: partial word discarded, no `rx_valid`; the word in the shift register is consumed (not returned to the buffer).
- `rx_valid` held until a cycle with `rx_ready` high, then cleared. Word completion while `rx_valid` is still high is an overrun: the new word overwrites `rx_data`, and `rx_valid` stays high. Completion and `rx_ready` in the same cycle: new word loaded, `rx_valid` stays high, no overrun.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `overrun`=0, state IDLE, buffers empty.
- Pin edge to internal edge detect: 3 `clk` cycles. `rx_valid` rises 1 cycle after the final sample edge is detected.
- `miso` changes 1 cycle after the detected shift edge, or after the `cs_n` fall for CPHA=0.
- Supported rate: `sclk` high and low phases each ≥ 4 `clk` periods; `cs_n` setup to first `sclk` edge ≥ 4 `clk`.
- Async reset mid-frame: immediate return to reset values. Frame resumes only after a fresh `cs_n` fall.

## Configuration
- `SPI_SECONDARY_OVERRUN_EN` defined: `overrun` set on any overrun event, held until `overrun_clr`. Set and clear in the same cycle: set wins.
- Undefined: `overrun` tied 0; `overrun_clr` ignored. Overwrite behaviour is unchanged.

## Structure
- Shared package `spi_pkg`: state enum (`SPI_IDLE`, `SPI_ACTIVE`) and edge-select helper constants derived from CPOL/CPHA.
- Sub-module `spi_sync_edge`: 2-flop synchronizer plus rise/fall detect. Instantiated for `sclk` and `cs_n`; `mosi` uses the synchronizer only.

## Test plan
- Mode 0, DWIDTH=8, tx 0xA5 preloaded, primary sends 0x3C -> `miso` carries 0xA5 MSB first; `rx_data`=0x3C, `rx_valid` for one word.
- All four CPOL/CPHA combos, DWIDTH=16, 0x1234 each way -> exact loopback in every mode.
- No tx word loaded, primary sends 0xFF -> `miso` all zeros; `rx_data`=0xFF.
- `cs_n` rises after 5 bits -> no `rx_valid`; next full frame 0x81 received correctly.
- Two back-to-back words 0x11 then 0x22 with `rx_ready`=0 -> `rx_data`=0x22, `overrun`=1 (macro on) or 0 (macro off); `overrun_clr` clears the flag.
- `rst` asserted mid-frame -> all outputs at reset values within the same cycle; the next frame is clean.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI secondary endpoint.
package spi_pkg;

  typedef enum logic [0:0] {
    SPI_IDLE   = 1'b0,
    SPI_ACTIVE = 1'b1
  } spi_state_e;

  // Sampling happens on the rising sclk edge exactly when CPOL equals CPHA.
  function automatic logic sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
      r_prev <= RST_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_lvl  = r_sync;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/spi_secondary.sv
// SPI secondary endpoint, oversampled in the clk domain, any CPOL/CPHA and width.
// Optional sticky overrun flag: define SPI_SECONDARY_OVERRUN_EN.
module spi_secondary
  import spi_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int          CW          = $clog2(DWIDTH);
  localparam logic        SCLK_IDLE   = (CPOL != 0);
  localparam logic        SAMPLE_RISE = sample_on_rise(CPOL != 0, CPHA != 0);
  localparam logic        EARLY_MSB   = (CPHA == 0);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DWIDTH - 1);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;

  spi_sync_edge #(.RST_VAL(SCLK_IDLE)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (sclk),
    .o_lvl  (w_sclk_lvl),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // cs_n resets low so a select held low across reset never looks like a fresh fall.
  spi_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .i_d    (cs_n),
    .o_lvl  (w_cs_lvl),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  logic              r_mosi_meta;
  logic              r_mosi_sync;
  spi_state_e        r_state;
  logic [CW-1:0]     r_bit_cnt;
  logic [DWIDTH-1:0] r_tx_buf;
  logic              r_tx_ready;
  logic [DWIDTH-1:0] r_tx_sr;
  logic [DWIDTH-1:0] r_rx_sr;
  logic [DWIDTH-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_miso;
  logic              r_miso_oe;
  logic              r_overrun;

  logic              w_unused_lvl;
  logic              w_sample;
  logic              w_shift;
  logic              w_start;
  logic              w_complete;
  logic              w_move;
  logic              w_ovr_evt;
  logic [DWIDTH-1:0] w_next_word;

  assign w_unused_lvl = w_sclk_lvl ^ w_cs_lvl;
  assign w_sample     = SAMPLE_RISE ? w_sclk_rise : w_sclk_fall;
  assign w_shift      = SAMPLE_RISE ? w_sclk_fall : w_sclk_rise;
  assign w_start      = (r_state == SPI_IDLE) && w_cs_fall;
  assign w_complete   = (r_state == SPI_ACTIVE) && !w_cs_rise && w_sample &&
                        (r_bit_cnt == LAST_BIT);
  assign w_move       = (w_start || w_complete) && !r_tx_ready;
  assign w_ovr_evt    = w_complete && r_rx_valid && !rx_ready;
  assign w_next_word  = r_tx_ready ? '0 : r_tx_buf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mosi_meta <= 1'b0;
      r_mosi_sync <= 1'b0;
    end else begin
      r_mosi_meta <= mosi;
      r_mosi_sync <= r_mosi_meta;
    end
  end

  // Holding buffer: load and move are exclusive since they need opposite tx_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_buf   <= '0;
      r_tx_ready <= 1'b1;
    end else if (tx_valid && r_tx_ready) begin
      r_tx_buf   <= tx_data;
      r_tx_ready <= 1'b0;
    end else if (w_move) begin
      r_tx_ready <= 1'b1;
    end else begin
      r_tx_ready <= r_tx_ready;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_valid <= 1'b0;
    end else if (w_complete) begin
      r_rx_valid <= 1'b1;
    end else if (rx_ready) begin
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= r_rx_valid;
    end
  end

  // r_tx_sr holds the bits not yet presented; each shift edge pops its MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= SPI_IDLE;
      r_bit_cnt <= '0;
      r_tx_sr   <= '0;
      r_rx_sr   <= '0;
      r_rx_data <= '0;
      r_miso    <= 1'b0;
      r_miso_oe <= 1'b0;
    end else begin
      case (r_state)
        SPI_IDLE: begin
          if (w_cs_fall) begin
            r_state   <= SPI_ACTIVE;
            r_miso_oe <= 1'b1;
            r_bit_cnt <= '0;
            if (EARLY_MSB) begin
              r_miso  <= w_next_word[DWIDTH-1];
              r_tx_sr <= {w_next_word[DWIDTH-2:0], 1'b0};
            end else begin
              r_miso  <= 1'b0;
              r_tx_sr <= w_next_word;
            end
          end
        end
        SPI_ACTIVE: begin
          if (w_cs_rise) begin
            r_state   <= SPI_IDLE;
            r_miso_oe <= 1'b0;
            r_miso    <= 1'b0;
            r_bit_cnt <= '0;
          end else if (w_sample) begin
            r_rx_sr <= {r_rx_sr[DWIDTH-2:0], r_mosi_sync};
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= '0;
              r_rx_data <= {r_rx_sr[DWIDTH-2:0], r_mosi_sync};
              r_tx_sr   <= w_next_word;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (w_shift) begin
            r_miso  <= r_tx_sr[DWIDTH-1];
            r_tx_sr <= {r_tx_sr[DWIDTH-2:0], 1'b0};
          end
        end
        default: begin
          r_state   <= SPI_IDLE;
          r_miso_oe <= 1'b0;
          r_miso    <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_SECONDARY_OVERRUN_EN
  logic w_unused_clr;
  assign w_unused_clr = 1'b0;

  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (w_ovr_evt) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= r_overrun;
    end
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = overrun_clr ^ w_ovr_evt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
    end
  end
`endif

  assign miso     = r_miso;
  assign miso_oe  = r_miso_oe;
  assign tx_ready = r_tx_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_spi_secondary.sv
// Directed bench: four 16-bit instances (one per SPI mode) and one 8-bit mode-0 instance.
module tb_spi_secondary;

  localparam int H = 6;
`ifdef SPI_SECONDARY_OVERRUN_EN
  localparam logic OVR_EXP = 1'b1;
`else
  localparam logic OVR_EXP = 1'b0;
`endif

  logic clk;
  logic rst;
  logic [4:0] sclk_v, cs_n_v, mosi_v, txv_v, rxr_v, oclr_v;
  wire  [4:0] miso_v, oe_v, txr_v, rxv_v, ovr_v;
  logic [3:0][15:0] tx16;
  wire  [3:0][15:0] rx16;
  logic [7:0] tx8;
  wire  [7:0] rx8;

  int n_cmp;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    spi_secondary #(.DWIDTH(16), .CPOL(m / 2), .CPHA(m % 2)) u_dut (
      .clk(clk), .rst(rst), .sclk(sclk_v[m]), .cs_n(cs_n_v[m]), .mosi(mosi_v[m]),
      .miso(miso_v[m]), .miso_oe(oe_v[m]), .tx_data(tx16[m]), .tx_valid(txv_v[m]),
      .tx_ready(txr_v[m]), .rx_data(rx16[m]), .rx_valid(rxv_v[m]), .rx_ready(rxr_v[m]),
      .overrun(ovr_v[m]), .overrun_clr(oclr_v[m])
    );
  end

  spi_secondary #(.DWIDTH(8), .CPOL(0), .CPHA(0)) u_dut8 (
    .clk(clk), .rst(rst), .sclk(sclk_v[4]), .cs_n(cs_n_v[4]), .mosi(mosi_v[4]),
    .miso(miso_v[4]), .miso_oe(oe_v[4]), .tx_data(tx8), .tx_valid(txv_v[4]),
    .tx_ready(txr_v[4]), .rx_data(rx8), .rx_valid(rxv_v[4]), .rx_ready(rxr_v[4]),
    .overrun(ovr_v[4]), .overrun_clr(oclr_v[4])
  );

  typedef struct {
    int          idx;
    logic [31:0] mosi_w;
    int          nbits;
    logic        ld;
    logic [15:0] tx_w;
    logic [31:0] exp_miso;
    logic [15:0] exp_rx;
    logic        exp_v;
  } vec_t;

  vec_t vecs [8];

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rxd(input int idx);
    return (idx == 4) ? {8'h00, rx8} : rx16[idx];
  endfunction

  task automatic load_tx(input int idx, input logic [15:0] w);
    if (idx == 4) tx8 = w[7:0];
    else tx16[idx] = w;
    txv_v[idx] = 1'b1;
    wclk(1);
    txv_v[idx] = 1'b0;
    chk("tx_ready_after_load", txr_v[idx], 1'b0);
  endtask

  // Primary-side frame: drives nbits of word MSB first and captures miso at sample edges.
  task automatic frame(input int idx, input logic [31:0] word, input int nbits,
                       input bit keep_cs, output logic [31:0] got);
    logic pol, pha;
    pol = (idx < 4) ? ((idx / 2) != 0) : 1'b0;
    pha = (idx < 4) ? ((idx % 2) != 0) : 1'b0;
    got = 32'h0;
    cs_n_v[idx] = 1'b0;
    wclk(H);
    chk("miso_oe_active", oe_v[idx], 1'b1);
    for (int i = 0; i < nbits; i++) begin
      if (!pha) begin
        mosi_v[idx] = word[nbits-1-i];
        wclk(H);
        got = {got[30:0], miso_v[idx]};
        sclk_v[idx] = ~pol;
        wclk(H);
        sclk_v[idx] = pol;
      end else begin
        sclk_v[idx] = ~pol;
        mosi_v[idx] = word[nbits-1-i];
        wclk(H);
        got = {got[30:0], miso_v[idx]};
        sclk_v[idx] = pol;
        wclk(H);
      end
    end
    wclk(H);
    if (!keep_cs) begin
      cs_n_v[idx] = 1'b1;
      wclk(2 * H);
      chk("miso_oe_idle", oe_v[idx], 1'b0);
    end
  endtask

  initial begin
    logic [31:0] got;
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b0;
    sclk_v = 5'b01100;
    cs_n_v = 5'b11111;
    mosi_v = 5'b00000;
    txv_v  = 5'b00000;
    rxr_v  = 5'b00000;
    oclr_v = 5'b00000;
    tx16   = '0;
    tx8    = 8'h00;

    vecs[0] = '{4, 32'h3C,   8,  1'b1, 16'hA5,   32'hA5,   16'h3C,   1'b1};
    vecs[1] = '{0, 32'h1234, 16, 1'b1, 16'h1234, 32'h1234, 16'h1234, 1'b1};
    vecs[2] = '{1, 32'h1234, 16, 1'b1, 16'h1234, 32'h1234, 16'h1234, 1'b1};
    vecs[3] = '{2, 32'h1234, 16, 1'b1, 16'h1234, 32'h1234, 16'h1234, 1'b1};
    vecs[4] = '{3, 32'h1234, 16, 1'b1, 16'h1234, 32'h1234, 16'h1234, 1'b1};
    vecs[5] = '{4, 32'hFF,   8,  1'b0, 16'h00,   32'h00,   16'hFF,   1'b1};
    vecs[6] = '{4, 32'h16,   5,  1'b0, 16'h00,   32'h00,   16'hFF,   1'b0};
    vecs[7] = '{4, 32'h81,   8,  1'b1, 16'h5A,   32'h5A,   16'h81,   1'b1};

    wclk(3);
    for (int k = 0; k < 5; k++) begin
      chk("rst_miso", miso_v[k], 1'b0);
      chk("rst_oe", oe_v[k], 1'b0);
      chk("rst_tx_ready", txr_v[k], 1'b1);
      chk("rst_rx_valid", rxv_v[k], 1'b0);
      chk("rst_rx_data", rxd(k), 16'h0);
      chk("rst_overrun", ovr_v[k], 1'b0);
    end
    rst = 1'b1;
    wclk(5);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].ld) load_tx(vecs[v].idx, vecs[v].tx_w);
      frame(vecs[v].idx, vecs[v].mosi_w, vecs[v].nbits, 1'b0, got);
      chk($sformatf("v%0d_miso", v), got, vecs[v].exp_miso);
      chk($sformatf("v%0d_rx_valid", v), rxv_v[vecs[v].idx], vecs[v].exp_v);
      chk($sformatf("v%0d_rx_data", v), rxd(vecs[v].idx), vecs[v].exp_rx);
      chk($sformatf("v%0d_tx_ready", v), txr_v[vecs[v].idx], 1'b1);
      chk($sformatf("v%0d_overrun", v), ovr_v[vecs[v].idx], 1'b0);
      if (vecs[v].exp_v) begin
        rxr_v[vecs[v].idx] = 1'b1;
        wclk(1);
        rxr_v[vecs[v].idx] = 1'b0;
        chk($sformatf("v%0d_rx_consumed", v), rxv_v[vecs[v].idx], 1'b0);
      end
    end

    // Back-to-back words with nobody reading: second overwrites first.
    frame(4, 32'h1122, 16, 1'b0, got);
    chk("b2b_miso", got, 32'h0);
    chk("b2b_rx_data", rxd(4), 16'h22);
    chk("b2b_rx_valid", rxv_v[4], 1'b1);
    chk("b2b_overrun", ovr_v[4], OVR_EXP);
    oclr_v[4] = 1'b1;
    wclk(1);
    oclr_v[4] = 1'b0;
    chk("overrun_cleared", ovr_v[4], 1'b0);
    chk("b2b_rx_still_valid", rxv_v[4], 1'b1);

    // Asynchronous reset in the middle of a frame, cs_n kept low throughout.
    load_tx(4, 16'h77);
    frame(4, 32'h5, 3, 1'b1, got);
    #3 rst = 1'b0;
    #1;
    chk("mid_rst_oe", oe_v[4], 1'b0);
    chk("mid_rst_miso", miso_v[4], 1'b0);
    chk("mid_rst_tx_ready", txr_v[4], 1'b1);
    chk("mid_rst_rx_valid", rxv_v[4], 1'b0);
    chk("mid_rst_rx_data", rxd(4), 16'h0);
    chk("mid_rst_overrun", ovr_v[4], 1'b0);
    @(negedge clk);
    rst = 1'b1;
    wclk(10);
    chk("no_resume_without_fall", oe_v[4], 1'b0);
    cs_n_v[4] = 1'b1;
    wclk(2 * H);
    load_tx(4, 16'h3C);
    frame(4, 32'hC3, 8, 1'b0, got);
    chk("post_rst_miso", got, 32'h3C);
    chk("post_rst_rx_data", rxd(4), 16'hC3);
    chk("post_rst_rx_valid", rxv_v[4], 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
